// File: rtl/r_l_controller_if.sv
// Bundle of the R/L mode request, load gate and phase/count outputs.
// The master drives the request and gate; the slave (the controller) drives the outputs.
interface r_l_controller_if;
  logic       R_L_con;
  logic       LOAD_G;
  logic       R_L_state;
  logic [7:0] load_cnt;
  logic [1:0] state_dbg;

  modport master (
    output R_L_con,
    output LOAD_G,
    input  R_L_state,
    input  load_cnt,
    input  state_dbg
  );

  modport slave (
    input  R_L_con,
    input  LOAD_G,
    output R_L_state,
    output load_cnt,
    output state_dbg
  );
endinterface

// File: rtl/r_l_controller.sv
// READ/LOAD phase controller: synchronises the asynchronous R_L_con request and
// counts LOAD_G rising edges while loading, only returning to READ with LOAD_G low.
module r_l_controller #(
  parameter int SYNC_STAGES     = 2,
  parameter int MIN_LOAD_PULSES = 1
) (
  input  logic             fdata_G,
  input  logic             rst,
  r_l_controller_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_READ = 2'd0,
    ST_LOAD = 2'd1,
    ST_EXIT = 2'd2
  } state_t;

  localparam logic [7:0] MIN_CNT = 8'(MIN_LOAD_PULSES);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   load_prev_q, load_prev_d;
  state_t                 state_q, state_d;
  logic                   r_l_state_q, r_l_state_d;
  logic [7:0]             cnt_q, cnt_d;
  logic                   con_s;
  logic                   load_rise;

  assign con_s     = sync_q[SYNC_STAGES-1];
  assign load_rise = bus.LOAD_G & ~load_prev_q;

  always_comb begin
    sync_d      = {sync_q[SYNC_STAGES-2:0], bus.R_L_con};
    load_prev_d = bus.LOAD_G;
    state_d     = state_q;
    cnt_d       = cnt_q;
    unique case (state_q)
      ST_READ: begin
        if (con_s) begin
          state_d = ST_LOAD;
          cnt_d   = 8'd0;
        end
      end
      ST_LOAD: begin
        // The edge is counted even when leaving; the threshold sees the old count.
        if (load_rise && (cnt_q != 8'hFF)) cnt_d = cnt_q + 8'd1;
        if (!con_s && (cnt_q >= MIN_CNT)) state_d = ST_EXIT;
      end
      ST_EXIT: begin
        if (con_s) begin
          state_d = ST_LOAD;
        end else if (!bus.LOAD_G) begin
          state_d = ST_READ;
          cnt_d   = 8'd0;
        end
      end
      default: begin
        state_d = ST_READ;
        cnt_d   = 8'd0;
      end
    endcase
    r_l_state_d = (state_d != ST_READ);
  end

  always_ff @(posedge fdata_G) begin
    if (rst) begin
      sync_q      <= '0;
      load_prev_q <= 1'b0;
      state_q     <= ST_READ;
      r_l_state_q <= 1'b0;
      cnt_q       <= 8'd0;
    end else begin
      sync_q      <= sync_d;
      load_prev_q <= load_prev_d;
      state_q     <= state_d;
      r_l_state_q <= r_l_state_d;
      cnt_q       <= cnt_d;
    end
  end

  assign bus.R_L_state = r_l_state_q;
  assign bus.load_cnt  = cnt_q;
  assign bus.state_dbg = state_q;

endmodule

// File: tb/tb_r_l_controller.sv
// Bench for r_l_controller: a default instance and a (SYNC_STAGES=3, MIN_LOAD_PULSES=3)
// instance share stimulus and are each compared against a phase/count reference model.
module tb_r_l_controller;

  logic fdata_G = 1'b0;
  logic rst     = 1'b1;
  logic con_drv = 1'b0;
  logic lg_drv  = 1'b0;

  int tests = 0;
  int fails = 0;

  always #5 fdata_G = ~fdata_G;

  r_l_controller_if ifa ();
  r_l_controller_if ifb ();

  assign ifa.R_L_con = con_drv;
  assign ifa.LOAD_G  = lg_drv;
  assign ifb.R_L_con = con_drv;
  assign ifb.LOAD_G  = lg_drv;

  r_l_controller #(.SYNC_STAGES(2), .MIN_LOAD_PULSES(1)) dut_a (
    .fdata_G (fdata_G),
    .rst     (rst),
    .bus     (ifa.slave)
  );

  r_l_controller #(.SYNC_STAGES(3), .MIN_LOAD_PULSES(3)) dut_b (
    .fdata_G (fdata_G),
    .rst     (rst),
    .bus     (ifb.slave)
  );

  // Reference model: phase 0 = READ, 1 = LOAD, 2 = waiting for LOAD_G low.
  // The synchroniser is a history of sampled R_L_con values seen S edges late.
  int S_ARR[2]   = '{2, 3};
  int MIN_ARR[2] = '{1, 3};
  int m_phase[2];
  int m_cnt[2];
  bit m_prev;
  bit con_log[$];

  task automatic model_step(input logic r, input logic c, input logic g);
    bit rise;
    if (r) begin
      con_log.delete();
      repeat (4) con_log.push_back(1'b0);
      m_prev = 1'b0;
      for (int i = 0; i < 2; i++) begin
        m_phase[i] = 0;
        m_cnt[i]   = 0;
      end
    end else begin
      rise = g && !m_prev;
      for (int i = 0; i < 2; i++) begin
        bit cs;
        int old;
        cs  = con_log[con_log.size() - S_ARR[i]];
        old = m_cnt[i];
        case (m_phase[i])
          0: if (cs) begin m_phase[i] = 1; m_cnt[i] = 0; end
          1: begin
            if (rise) m_cnt[i] = (old < 255) ? old + 1 : 255;
            if (!cs && old >= MIN_ARR[i]) m_phase[i] = 2;
          end
          default: begin
            if (cs) m_phase[i] = 1;
            else if (!g) begin m_phase[i] = 0; m_cnt[i] = 0; end
          end
        endcase
      end
      con_log.push_back(c);
      if (con_log.size() > 8) void'(con_log.pop_front());
      m_prev = g;
    end
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input logic r, input logic c, input logic g);
    rst     = r;
    con_drv = c;
    lg_drv  = g;
    @(posedge fdata_G);
    model_step(r, c, g);
    #1;
    check("a_state", {7'd0, ifa.R_L_state}, {7'd0, (m_phase[0] != 0)});
    check("a_cnt",   ifa.load_cnt,          8'(m_cnt[0]));
    check("b_state", {7'd0, ifb.R_L_state}, {7'd0, (m_phase[1] != 0)});
    check("b_cnt",   ifb.load_cnt,          8'(m_cnt[1]));
  endtask

  task automatic pulses(input int n, input logic c);
    for (int k = 0; k < n; k++) begin
      tick(1'b0, c, 1'b1);
      tick(1'b0, c, 1'b1);
      tick(1'b0, c, 1'b0);
      tick(1'b0, c, 1'b0);
    end
  endtask

  initial begin
    logic [7:0] rec;
    int run;
    logic cv;

    con_log.delete();
    repeat (4) con_log.push_back(1'b0);

    // Reset
    tick(1'b1, 1'b0, 1'b0);
    tick(1'b1, 1'b0, 1'b0);
    check("rst_state", {7'd0, ifa.R_L_state}, 8'd0);
    check("rst_cnt", ifa.load_cnt, 8'd0);

    // R_L_con raised: LOAD appears on the third edge
    tick(1'b0, 1'b1, 1'b0);
    check("entry_e1", {7'd0, ifa.R_L_state}, 8'd0);
    tick(1'b0, 1'b1, 1'b0);
    check("entry_e2", {7'd0, ifa.R_L_state}, 8'd0);
    tick(1'b0, 1'b1, 1'b0);
    check("entry_e3", {7'd0, ifa.R_L_state}, 8'd1);
    check("entry_cnt", ifa.load_cnt, 8'd0);

    // Five pulses, then release to READ
    pulses(5, 1'b1);
    check("five_pulses", ifa.load_cnt, 8'd5);
    repeat (6) tick(1'b0, 1'b0, 1'b0);
    check("back_read_state", {7'd0, ifa.R_L_state}, 8'd0);
    check("back_read_cnt", ifa.load_cnt, 8'd0);

    // EXIT held while LOAD_G stays high
    repeat (6) tick(1'b0, 1'b1, 1'b0);
    pulses(4, 1'b1);
    repeat (12) tick(1'b0, 1'b0, 1'b1);
    check("exit_hold", {7'd0, ifa.R_L_state}, 8'd1);
    tick(1'b0, 1'b0, 1'b0);
    check("exit_release", {7'd0, ifa.R_L_state}, 8'd0);
    repeat (4) tick(1'b0, 1'b0, 1'b0);

    // Re-entry from EXIT keeps the count
    repeat (6) tick(1'b0, 1'b1, 1'b0);
    pulses(3, 1'b1);
    repeat (6) tick(1'b0, 1'b0, 1'b1);
    rec = ifa.load_cnt;
    repeat (3) tick(1'b0, 1'b1, 1'b1);
    check("reenter_state", {7'd0, ifa.R_L_state}, 8'd1);
    check("reenter_cnt", ifa.load_cnt, rec);
    for (int k = 0; k < 2; k++) begin
      tick(1'b0, 1'b1, 1'b0);
      tick(1'b0, 1'b1, 1'b0);
      tick(1'b0, 1'b1, 1'b1);
      tick(1'b0, 1'b1, 1'b1);
    end
    check("resume_cnt", ifa.load_cnt, rec + 8'd2);
    repeat (8) tick(1'b0, 1'b0, 1'b0);

    // Short R_L_con pulse against the MIN_LOAD_PULSES=3 instance
    repeat (4) tick(1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 10; k++) tick(1'b0, 1'b0, 1'(k % 2));
    repeat (4) tick(1'b0, 1'b0, 1'b0);

    // Randomised request / gate activity
    run = 0;
    cv  = 1'b0;
    for (int k = 0; k < 400; k++) begin
      if (run == 0) begin
        cv  = 1'($urandom_range(0, 1));
        run = $urandom_range(1, 12);
      end
      run--;
      tick(1'b0, cv, 1'($urandom_range(0, 1)));
    end
    repeat (8) tick(1'b0, 1'b0, 1'b0);

    // Saturation, then reset mid-LOAD
    repeat (5) tick(1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 300; k++) begin
      tick(1'b0, 1'b1, 1'b1);
      tick(1'b0, 1'b1, 1'b0);
    end
    check("sat_a", ifa.load_cnt, 8'd255);
    check("sat_b", ifb.load_cnt, 8'd255);
    tick(1'b1, 1'b1, 1'b1);
    check("rst_mid_state", {7'd0, ifa.R_L_state}, 8'd0);
    check("rst_mid_cnt", ifa.load_cnt, 8'd0);

    // R_L_con already high when reset releases
    tick(1'b0, 1'b1, 1'b0);
    check("post_rst_e1", {7'd0, ifa.R_L_state}, 8'd0);
    tick(1'b0, 1'b1, 1'b0);
    check("post_rst_e2", {7'd0, ifa.R_L_state}, 8'd0);
    tick(1'b0, 1'b1, 1'b0);
    check("post_rst_e3", {7'd0, ifa.R_L_state}, 8'd1);
    repeat (6) tick(1'b0, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/r_l_controller.md
R_L_CONTROLLER -- requirements
Module: r_l_controller

Interface
REQ-001 Parameter SYNC_STAGES, default 2, number of flops in the R_L_con synchronizer (legal range 2..4).
REQ-002 Parameter MIN_LOAD_PULSES, default 1, minimum LOAD_G rising edges counted in LOAD before exit is allowed (legal range 0..255).
REQ-003 fdata_G  input  1  sole clock (1024 kHz gate clock); all flops on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 R_L_con  input  1  asynchronous mode request; 1 = request LOAD phase, 0 = request READ phase.
REQ-006 LOAD_G  input  1  load gate from the clock generator, sampled as data on the rising edge of fdata_G.
REQ-007 R_L_state  output  1  registered phase flag; 1 = LOAD phase, 0 = READ phase.
REQ-008 load_cnt  output  8  registered count of LOAD_G rising edges in the current LOAD phase.

Function
REQ-009 R_L_con SHALL pass through a SYNC_STAGES-deep flop chain; con_s (last stage) SHALL be the only internal use of R_L_con.
REQ-010 load_prev SHALL register LOAD_G every cycle; a rising edge is LOAD_G=1 and load_prev=0 in the same cycle.
REQ-011 The FSM SHALL have three states: READ, LOAD and EXIT.
REQ-012 R_L_state SHALL be 0 in READ and 1 in LOAD and EXIT, driven directly from a state register with no combinational path from inputs.
REQ-013 READ to LOAD SHALL occur on the first rising edge where con_s=1; load_cnt SHALL be 0 on entry.
REQ-014 R_L_state SHALL rise exactly SYNC_STAGES+1 rising edges after the first edge that samples R_L_con=1.
REQ-015 In LOAD, each rising edge SHALL increment load_cnt by 1; the count SHALL saturate at 255 and never wrap.
REQ-016 Rising edges SHALL NOT be counted in READ or EXIT.
REQ-017 LOAD to EXIT SHALL occur when con_s=0 and load_cnt>=MIN_LOAD_PULSES, both evaluated on the same edge.
REQ-018 If con_s=0 and load_cnt<MIN_LOAD_PULSES, the FSM SHALL stay in LOAD and keep counting until the threshold is reached.
REQ-019 EXIT to READ SHALL occur on the first edge with LOAD_G=0 (sampled); load_cnt SHALL clear to 0 on that same edge.
REQ-020 EXIT with LOAD_G=1 SHALL hold EXIT, so READ never starts while LOAD_G is high.
REQ-021 EXIT with con_s=1 SHALL return to LOAD with load_cnt retained; this takes priority over REQ-019 on the same edge.
REQ-022 A rising edge and an exit condition on the same edge SHALL count the edge first; the threshold then uses the pre-increment value.
REQ-023 Glitches on R_L_con shorter than one fdata_G period need not be seen; any change held for at least SYNC_STAGES+1 periods SHALL be acted on.

Reset
REQ-024 When rst=1 at a rising edge, all flops SHALL clear: synchronizer stages 0, load_prev 0, state READ, R_L_state 0, load_cnt 0.
REQ-025 Reset asserted mid-LOAD or mid-EXIT SHALL force READ on that edge regardless of LOAD_G or R_L_con.
REQ-026 After rst falls, R_L_con=1 already present SHALL be honoured per REQ-014, counted from the first non-reset edge.

Verification
REQ-027 Reset, then R_L_con=1 held (defaults) -> R_L_state 0 for 2 edges, 1 from the 3rd edge; load_cnt=0.
REQ-028 In LOAD, 5 LOAD_G pulses (2 high, 2 low cycles), then R_L_con=0 with LOAD_G low -> load_cnt=5, EXIT, then READ; R_L_state=0 and load_cnt=0 one edge after EXIT.
REQ-029 MIN_LOAD_PULSES=3, R_L_con pulsed high for 4 cycles, LOAD_G toggling -> R_L_state stays 1 until load_cnt=3, then returns to 0 only on an edge with LOAD_G=0.
REQ-030 In EXIT with LOAD_G held high 10 cycles -> R_L_state stays 1; LOAD_G falls -> R_L_state 0 the next edge.
REQ-031 In EXIT, R_L_con reasserted -> LOAD re-entered, load_cnt unchanged and resumes counting.
REQ-032 300 LOAD_G pulses in LOAD -> load_cnt saturates at 255; rst=1 mid-LOAD -> R_L_state=0 and load_cnt=0 on the next edge.
